alu_share_arb: RTL and testbench

Two-requester round-robin arbiter that time-shares the single combinational 32-bit ALU (add/sub/logic/shift/compare) in the NPC datapath. Requester 0 is the EXU and requester 1 is the LSU address path. The block:
- accepts one operation per cycle over valid/ready;
- drives the shared ALU's operand and opcode inputs;
- captures the ALU output into one result register;
- returns it to the winning requester over a registered valid/ready response channel.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_share_arb_rr_arb2.sv | 18 +
 rtl/alu_share_arb.sv | 116 +++++++++++
 tb/tb_alu_share_arb.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU sharing arbiter: ALU opcode encoding and the
// result-register ownership states.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_SLL  = 4'd5,
      OP_SRL  = 4'd6,
      OP_SRA  = 4'd7,
      OP_SLT  = 4'd8,
      OP_SLTU = 4'd9
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD0 = 2'd1,
      HOLD1 = 2'd2
   } arb_state_t;

endpackage

// File: rtl/alu_share_arb_rr_arb2.sv
// Two-way round-robin grant. Nothing is granted unless the result register
// is free; on contention the prio pointer picks the winner (0 = requester 0).
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       prio,
   input  logic       free,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (free) begin
         if (req == 2'b11) grant = prio ? 2'b10 : 2'b01;
         else              grant = req;
      end
   end

endmodule

// File: rtl/alu_share_arb.sv
// Time-shares one combinational ALU between the EXU (requester 0) and the
// LSU address path (requester 1), returning results through one register.
//
//   state | meaning
//   IDLE  | result register empty
//   HOLD0 | result register owned by requester 0
//   HOLD1 | result register owned by requester 1
module alu_share_arb
   import alu_pkg::*;
#(
   parameter int W     = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             r0_valid,
   output logic             r0_ready,
   input  logic [3:0]       r0_op,
   input  logic [W-1:0]     r0_a,
   input  logic [W-1:0]     r0_b,
   output logic             r0_rvalid,
   input  logic             r0_rready,
   output logic [W-1:0]     r0_result,
   input  logic             r1_valid,
   output logic             r1_ready,
   input  logic [3:0]       r1_op,
   input  logic [W-1:0]     r1_a,
   input  logic [W-1:0]     r1_b,
   output logic             r1_rvalid,
   input  logic             r1_rready,
   output logic [W-1:0]     r1_result,
   output logic [3:0]       alu_op,
   output logic [W-1:0]     alu_a,
   output logic [W-1:0]     alu_b,
   input  logic [W-1:0]     alu_s,
   output logic [CNT_W-1:0] conflict_cnt
);

   arb_state_t   state;
   logic         prio;
   logic [W-1:0] result_q;
   logic         free;
   logic [1:0]   grant_raw;
   logic [1:0]   grant;
   logic         both_req;

   // A holder that is consuming its result this cycle frees the register,
   // so release and the next grant happen in the same cycle.
   always_comb begin
      free = 1'b0;
      case (state)
         IDLE:    free = 1'b1;
         HOLD0:   free = r0_rready;
         HOLD1:   free = r1_rready;
         default: free = 1'b1;
      endcase
   end

   rr_arb2 u_rr_arb2 (
      .req   ({r1_valid, r0_valid}),
      .prio  (prio),
      .free  (free),
      .grant (grant_raw)
   );

   assign grant    = rst ? 2'b00 : grant_raw;
   assign both_req = r0_valid & r1_valid;

   assign r0_ready  = grant[0];
   assign r1_ready  = grant[1];
   assign r0_rvalid = (state == HOLD0);
   assign r1_rvalid = (state == HOLD1);
   assign r0_result = result_q;
   assign r1_result = result_q;

   always_comb begin
      alu_op = 4'd0;
      alu_a  = '0;
      alu_b  = '0;
      if (grant[0]) begin
         alu_op = r0_op;
         alu_a  = r0_a;
         alu_b  = r0_b;
      end else if (grant[1]) begin
         alu_op = r1_op;
         alu_a  = r1_a;
         alu_b  = r1_b;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         prio         <= 1'b0;
         result_q     <= '0;
         conflict_cnt <= '0;
      end else begin
         if (free) begin
            if (grant[0]) begin
               state    <= HOLD0;
               result_q <= alu_s;
               prio     <= 1'b1;
            end else if (grant[1]) begin
               state    <= HOLD1;
               result_q <= alu_s;
               prio     <= 1'b0;
            end else begin
               state    <= IDLE;
            end
         end
         if ((|grant) && both_req && (conflict_cnt != {CNT_W{1'b1}}))
            conflict_cnt <= conflict_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: directed scenarios plus a randomized
// run against a transaction-level ownership model.
module tb_alu_share_arb;

   localparam int W     = 32;
   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic             clk = 1'b0;
   logic             rst;
   logic             r0_valid, r0_ready, r0_rvalid, r0_rready;
   logic [3:0]       r0_op;
   logic [W-1:0]     r0_a, r0_b, r0_result;
   logic             r1_valid, r1_ready, r1_rvalid, r1_rready;
   logic [3:0]       r1_op;
   logic [W-1:0]     r1_a, r1_b, r1_result;
   logic [3:0]       alu_op;
   logic [W-1:0]     alu_a, alu_b, alu_s;
   logic [CNT_W-1:0] conflict_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   function automatic logic [W-1:0] alu_f(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return a << b[4:0];
         4'd6:    return a >> b[4:0];
         4'd7:    return W'($signed(a) >>> b[4:0]);
         4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd9:    return (a < b) ? 32'd1 : 32'd0;
         default: return '0;
      endcase
   endfunction

   assign alu_s = alu_f(alu_op, alu_a, alu_b);

   alu_share_arb #(.W(W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
      .r0_rvalid(r0_rvalid), .r0_rready(r0_rready), .r0_result(r0_result),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
      .r1_rvalid(r1_rvalid), .r1_rready(r1_rready), .r1_result(r1_result),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
      .conflict_cnt(conflict_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      r0_valid = 0; r0_rready = 0; r0_op = 0; r0_a = 0; r0_b = 0;
      r1_valid = 0; r1_rready = 0; r1_op = 0; r1_a = 0; r1_b = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      tick();
      tick();
      rst = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1;
      tick();
      tick();
      r0_valid = 1; r1_valid = 1; r0_op = 4'd1; r0_a = 32'h55; r1_a = 32'h77;
      #1;
      n_checks++;
      if ({r0_ready, r1_ready} !== 2'b00) begin
         n_fail++; $display("FAIL reset_ready got %b want 00", {r0_ready, r1_ready});
      end
      n_checks++;
      if ({r0_rvalid, r1_rvalid} !== 2'b00) begin
         n_fail++; $display("FAIL reset_rvalid got %b want 00", {r0_rvalid, r1_rvalid});
      end
      n_checks++;
      if (r0_result !== 32'd0 || conflict_cnt !== 4'd0) begin
         n_fail++; $display("FAIL reset_regs result %h cnt %0d want 0 0", r0_result, conflict_cnt);
      end
      n_checks++;
      if (alu_op !== 4'd0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
         n_fail++; $display("FAIL reset_alu got op %0d a %h b %h want zeros", alu_op, alu_a, alu_b);
      end
      idle_inputs();
      rst = 0;
      tick();
   endtask

   task automatic test_single_op();
      do_reset();
      r0_valid = 1; r0_op = 4'd3; r0_a = 32'hF0F0_0000; r0_b = 32'h0000_0F0F; r0_rready = 1;
      #1;
      n_checks++;
      if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
         n_fail++; $display("FAIL single_ready got %b%b want 10", r0_ready, r1_ready);
      end
      n_checks++;
      if (alu_op !== 4'd3 || alu_a !== 32'hF0F0_0000 || alu_b !== 32'h0000_0F0F) begin
         n_fail++; $display("FAIL single_alu got op %0d a %h b %h", alu_op, alu_a, alu_b);
      end
      tick();
      r0_valid = 0;
      n_checks++;
      if (r0_rvalid !== 1'b1 || r1_rvalid !== 1'b0 || r0_result !== 32'hF0F0_0F0F) begin
         n_fail++;
         $display("FAIL single_result rvalid %b%b result %h want 10 f0f00f0f", r0_rvalid, r1_rvalid, r0_result);
      end
      tick();
      n_checks++;
      if (r0_rvalid !== 1'b0) begin
         n_fail++; $display("FAIL single_release r0_rvalid %b want 0", r0_rvalid);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      r0_valid = 1; r0_op = 4'd0; r0_a = 1; r0_b = 2; r0_rready = 1;
      r1_valid = 1; r1_op = 4'd1; r1_a = 5; r1_b = 3; r1_rready = 1;
      #1;
      n_checks++;
      if ({r0_ready, r1_ready} !== 2'b10) begin
         n_fail++; $display("FAIL simul_first got %b%b want 10", r0_ready, r1_ready);
      end
      tick();
      r0_valid = 0;
      n_checks++;
      if (r0_rvalid !== 1'b1 || r0_result !== 32'd3 || conflict_cnt !== 4'd1) begin
         n_fail++; $display("FAIL simul_r0 rvalid %b result %0d cnt %0d want 1 3 1", r0_rvalid, r0_result, conflict_cnt);
      end
      #1;
      n_checks++;
      if (r1_ready !== 1'b1) begin
         n_fail++; $display("FAIL simul_second r1_ready %b want 1", r1_ready);
      end
      tick();
      r1_valid = 0;
      n_checks++;
      if (r1_rvalid !== 1'b1 || r0_rvalid !== 1'b0 || r1_result !== 32'd2 || conflict_cnt !== 4'd1) begin
         n_fail++;
         $display("FAIL simul_r1 rvalid %b%b result %0d cnt %0d want 01 2 1", r0_rvalid, r1_rvalid, r1_result, conflict_cnt);
      end
      tick();
   endtask

   task automatic test_fairness();
      int rem0 = 5;
      int rem1 = 5;
      logic [W-1:0] exp_res;
      do_reset();
      r0_rready = 1; r1_rready = 1;
      for (int k = 0; k < 10; k++) begin
         r0_valid = (rem0 > 0); r1_valid = (rem1 > 0);
         r0_op = 4'($urandom_range(0, 9)); r0_a = $urandom; r0_b = $urandom;
         r1_op = 4'($urandom_range(0, 9)); r1_a = $urandom; r1_b = $urandom;
         #1;
         n_checks++;
         if ({r1_ready, r0_ready} !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
            n_fail++; $display("FAIL fair_grant k=%0d got r1r0=%b%b", k, r1_ready, r0_ready);
         end
         exp_res = (k % 2 == 0) ? alu_f(r0_op, r0_a, r0_b) : alu_f(r1_op, r1_a, r1_b);
         tick();
         if (k % 2 == 0) rem0--; else rem1--;
         n_checks++;
         if (r0_result !== exp_res) begin
            n_fail++; $display("FAIL fair_result k=%0d got %h want %h", k, r0_result, exp_res);
         end
      end
      r0_valid = 0; r1_valid = 0;
      n_checks++;
      if (conflict_cnt !== 4'd9) begin
         n_fail++; $display("FAIL fair_cnt got %0d want 9", conflict_cnt);
      end
      tick();
   endtask

   task automatic test_backpressure();
      logic [W-1:0] exp0, exp1;
      do_reset();
      r0_valid = 1; r0_op = 4'd4; r0_a = $urandom; r0_b = $urandom; r0_rready = 0;
      exp0 = r0_a ^ r0_b;
      tick();
      r0_valid = 0;
      r1_valid = 1; r1_op = 4'd0; r1_a = $urandom; r1_b = $urandom; r1_rready = 1;
      exp1 = r1_a + r1_b;
      for (int k = 0; k < 5; k++) begin
         #1;
         n_checks++;
         if (r1_ready !== 1'b0 || alu_op !== 4'd0 || alu_a !== 32'd0) begin
            n_fail++; $display("FAIL bp_stall k=%0d r1_ready %b alu_op %0d alu_a %h", k, r1_ready, alu_op, alu_a);
         end
         n_checks++;
         if (r0_rvalid !== 1'b1 || r0_result !== exp0) begin
            n_fail++; $display("FAIL bp_hold k=%0d rvalid %b result %h want 1 %h", k, r0_rvalid, r0_result, exp0);
         end
         tick();
      end
      r0_rready = 1;
      #1;
      n_checks++;
      if (r1_ready !== 1'b1) begin
         n_fail++; $display("FAIL bp_release r1_ready %b want 1", r1_ready);
      end
      tick();
      r1_valid = 0;
      n_checks++;
      if (r1_rvalid !== 1'b1 || r0_rvalid !== 1'b0 || r1_result !== exp1) begin
         n_fail++; $display("FAIL bp_handoff rvalid %b%b result %h want 01 %h", r0_rvalid, r1_rvalid, r1_result, exp1);
      end
      tick();
   endtask

   task automatic test_reset_mid_op();
      do_reset();
      r0_valid = 1; r0_op = 0; r0_a = 10; r0_b = 20; r0_rready = 0;
      r1_valid = 1; r1_op = 1; r1_a = 50; r1_b = 8;  r1_rready = 0;
      tick();
      r0_valid = 0; r0_rready = 1;
      tick();
      r0_rready = 0;
      n_checks++;
      if (r1_rvalid !== 1'b1 || r1_result !== 32'd42 || conflict_cnt !== 4'd1) begin
         n_fail++; $display("FAIL midrst_setup rvalid %b result %0d cnt %0d want 1 42 1", r1_rvalid, r1_result, conflict_cnt);
      end
      rst = 1;
      tick();
      r1_valid = 0;
      n_checks++;
      if (r1_rvalid !== 1'b0 || r1_result !== 32'd0 || conflict_cnt !== 4'd0) begin
         n_fail++; $display("FAIL midrst_clear rvalid %b result %h cnt %0d want 0 0 0", r1_rvalid, r1_result, conflict_cnt);
      end
      rst = 0;
      r0_valid = 1; r1_valid = 1; r1_rready = 1;
      #1;
      n_checks++;
      if ({r0_ready, r1_ready} !== 2'b10) begin
         n_fail++; $display("FAIL midrst_prio got %b%b want 10", r0_ready, r1_ready);
      end
      tick();
      n_checks++;
      if (r1_rvalid !== 1'b0 || r0_rvalid !== 1'b1 || r0_result !== 32'd30) begin
         n_fail++; $display("FAIL midrst_after rvalid %b%b result %0d want 10 30", r0_rvalid, r1_rvalid, r0_result);
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_saturation();
      logic [CNT_W-1:0] exp_cnt = '0;
      do_reset();
      r0_valid = 1; r1_valid = 1; r0_rready = 1; r1_rready = 1;
      for (int k = 0; k < 20; k++) begin
         r0_a = $urandom; r1_a = $urandom;
         tick();
         if (exp_cnt != CNT_MAX) exp_cnt = exp_cnt + 1'b1;
         n_checks++;
         if (conflict_cnt !== exp_cnt) begin
            n_fail++; $display("FAIL sat_cnt k=%0d got %0d want %0d", k, conflict_cnt, exp_cnt);
         end
      end
      idle_inputs();
      tick();
   endtask

   // Transaction-level model: who owns the result register, what it holds,
   // whose turn it is on contention, and how many contested grants occurred.
   task automatic test_random();
      int owner = -1;
      int turn = 0;
      int winner;
      int conflicts = 0;
      logic [W-1:0] held = '0;
      logic v0 = 0, v1 = 0;
      logic rr0, rr1, free;
      logic [3:0] exp_op;
      logic [W-1:0] exp_a, exp_b;
      do_reset();
      for (int k = 0; k < 400; k++) begin
         if (!v0) begin
            v0 = ($urandom_range(0, 99) < 60);
            r0_op = 4'($urandom_range(0, 15)); r0_a = $urandom; r0_b = $urandom;
         end
         if (!v1) begin
            v1 = ($urandom_range(0, 99) < 60);
            r1_op = 4'($urandom_range(0, 15)); r1_a = $urandom; r1_b = $urandom;
         end
         rr0 = ($urandom_range(0, 99) < 70);
         rr1 = ($urandom_range(0, 99) < 70);
         r0_valid = v0; r1_valid = v1; r0_rready = rr0; r1_rready = rr1;
         free = (owner == -1) || (owner == 0 && rr0) || (owner == 1 && rr1);
         winner = -1;
         if (free) begin
            if (v0 && v1) winner = turn;
            else if (v0)  winner = 0;
            else if (v1)  winner = 1;
         end
         exp_op = 0; exp_a = 0; exp_b = 0;
         if (winner == 0) begin exp_op = r0_op; exp_a = r0_a; exp_b = r0_b; end
         if (winner == 1) begin exp_op = r1_op; exp_a = r1_a; exp_b = r1_b; end
         #1;
         n_checks++;
         if (r0_ready !== (winner == 0) || r1_ready !== (winner == 1)) begin
            n_fail++; $display("FAIL rand_ready k=%0d got %b%b want winner %0d", k, r0_ready, r1_ready, winner);
         end
         n_checks++;
         if (alu_op !== exp_op || alu_a !== exp_a || alu_b !== exp_b) begin
            n_fail++; $display("FAIL rand_alu k=%0d got %0d %h %h want %0d %h %h", k, alu_op, alu_a, alu_b, exp_op, exp_a, exp_b);
         end
         tick();
         if (winner >= 0) begin
            held = alu_f(exp_op, exp_a, exp_b);
            if (v0 && v1 && conflicts < 15) conflicts++;
            turn = 1 - winner;
            owner = winner;
            if (winner == 0) v0 = 0; else v1 = 0;
         end else if (free) begin
            owner = -1;
         end
         n_checks++;
         if (r0_rvalid !== (owner == 0) || r1_rvalid !== (owner == 1) || r0_result !== held ||
             r1_result !== held || conflict_cnt !== CNT_W'(conflicts)) begin
            n_fail++;
            $display("FAIL rand_state k=%0d rvalid %b%b result %h cnt %0d want owner %0d result %h cnt %0d",
                     k, r0_rvalid, r1_rvalid, r0_result, conflict_cnt, owner, held, conflicts);
         end
      end
      idle_inputs();
      tick();
   endtask

   initial begin
      idle_inputs();
      rst = 1;
      test_reset();
      test_single_op();
      test_simultaneous();
      test_fairness();
      test_backpressure();
      test_reset_mid_op();
      test_saturation();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
